// File: rtl/audiodac_nco_sinegen.sv
// Multi-channel NCO sine generator: phase accumulator, quarter-wave LUT, per-channel phase offset.
// Latency: one read edge -> data_o updated on that edge (pre-increment phase).
// No backpressure: the DAC pulls with data_rd_i, and outputs hold between reads.
// Optional: define AUDIODAC_SINEGEN_DITHER_EN for a 1-LSB LFSR dither on every read.
module audiodac_nco_sinegen #(
  parameter int  BW        = 16,
  parameter int  PHASE_BW  = 16,
  parameter int  LUT_SIZE  = 6,
  parameter int  NCH       = 2,
  parameter real SINE_AMPL = 0.9
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                data_rd_i,
  input  logic                tst_sinegen_en_i,
  input  logic [PHASE_BW-1:0] tst_sinegen_step_i,
  input  logic [PHASE_BW-1:0] tst_sinegen_ofs_i,
  input  logic [3:0]          tst_sinegen_att_i,
  output logic [NCH*BW-1:0]   data_o,
  output logic                active_o
);

  localparam int N = 2**LUT_SIZE;
  localparam logic [LUT_SIZE:0] N_IDX = (LUT_SIZE+1)'(N);
  localparam logic signed [BW-1:0] SMAX = {1'b0, {(BW-1){1'b1}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  // Quarter-wave table entry, truncated toward zero; evaluated with constant arguments only.
  function automatic logic signed [BW-1:0] lut_val(input int k);
    real ang;
    real v;
    ang = real'(k) * 3.14159265358979323846 / (2.0 * real'(N));
    v   = SINE_AMPL * (real'(2**(BW-1)) - 1.0) * $sin(ang);
    return BW'($rtoi(v));
  endfunction

  logic signed [BW-1:0] lut_w [0:N];

  for (genvar k = 0; k <= N; k++) begin : g_lut
    assign lut_w[k] = lut_val(k);
  end

  // Fold a full-wave phase onto the quarter table, then attenuate. Low phase bits are dropped.
  function automatic logic signed [BW-1:0] fold_att(input logic [PHASE_BW-1:0] p,
                                                    input logic [3:0]          att);
    logic [1:0]           q;
    logic [LUT_SIZE-1:0]  j;
    logic [LUT_SIZE:0]    idx;
    logic signed [BW-1:0] m;
    q   = p[PHASE_BW-1 -: 2];
    j   = p[PHASE_BW-3 -: LUT_SIZE];
    idx = q[0] ? (N_IDX - {1'b0, j}) : {1'b0, j};
    m   = lut_w[idx];
    if (q[1]) m = -m;
    return m >>> att;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [PHASE_BW-1:0] phase_q, phase_d;
  logic                carry_q, carry_d;
  logic [NCH*BW-1:0]   data_q, data_d;
  logic                do_read;
  logic                do_zero;
  logic                dith_bit;

  logic [PHASE_BW-1:0]  ch_ph;
  logic signed [BW-1:0] ch_s;
  logic [NCH*BW-1:0]    samp;

`ifdef AUDIODAC_SINEGEN_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped on every accepted read.
  always_comb begin
    lfsr_d = lfsr_q;
    if (do_read || (do_zero && data_rd_i))
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register; reseeded on reset so dither patterns are reproducible.
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign dith_bit = lfsr_q[0];
`else
  assign dith_bit = 1'b0;
`endif

  // Per-channel samples from the current (pre-increment) phase; channel c sits c*ofs ahead.
  always_comb begin
    samp  = '0;
    ch_ph = phase_q;
    ch_s  = '0;
    for (int c = 0; c < NCH; c++) begin
      ch_s = fold_att(ch_ph, tst_sinegen_att_i);
      if (dith_bit && (ch_s != SMAX)) ch_s = ch_s + BW'(1);
      samp[c*BW +: BW] = ch_s;
      ch_ph = ch_ph + tst_sinegen_ofs_i;
    end
  end

  // State machine and datapath next-state. In STOP, enable wins over the drain to zero.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    carry_d = carry_q;
    data_d  = data_q;
    do_read = 1'b0;
    do_zero = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tst_sinegen_en_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        do_read = data_rd_i;
        if (!tst_sinegen_en_i) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tst_sinegen_en_i) begin
          state_d = ST_RUN;
          do_read = data_rd_i;
        end else if ((tst_sinegen_step_i == '0) || (data_rd_i && carry_q)) begin
          // Phase has wrapped (or will never advance): park at a zero crossing.
          state_d = ST_IDLE;
          do_zero = 1'b1;
        end else begin
          do_read = data_rd_i;
        end
      end
      default: begin
        state_d = ST_IDLE;
        do_zero = 1'b1;
      end
    endcase
    if (do_read) begin
      data_d = samp;
      {carry_d, phase_d} = {1'b0, phase_q} + {1'b0, tst_sinegen_step_i};
    end
    if (do_zero) begin
      data_d  = '0;
      phase_d = '0;
      carry_d = 1'b0;
    end
  end

  // State registers; reset overrides everything including a drain in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      carry_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      carry_q <= carry_d;
      data_q  <= data_d;
    end
  end

  assign data_o   = data_q;
  assign active_o = (state_q != ST_IDLE);

endmodule
